// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared types and helpers for the memory-stage data port.
//   StateT     : responder FSM states (IDLE, RBUSY, RESP, DUMP, DONE)
//   word_index : byte address -> word index into the data array
//   addr_err   : request rejection test (bad kind, misaligned, out of range)
package cpu_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int LAT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RBUSY,
        RESP,
        DUMP,
        DONE
    } StateT;

    // Word index: drop the two byte-offset bits, keep ADDR_W word bits.
    function automatic logic [ADDR_W-1:0] word_index(input logic [DATA_W-1:0] addr);
        return addr[ADDR_W+1:2];
    endfunction

    // A request is rejected when it is neither a pure load nor a pure store,
    // when it is not word aligned, or when it lies beyond the array.
    function automatic logic addr_err(input logic [DATA_W-1:0] addr,
                                      input logic              rd,
                                      input logic              wr);
        return (rd == wr) || (addr[1:0] != 2'b00) || (addr[DATA_W-1:ADDR_W+2] != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Word-addressed storage, 2**AW words of N bits, no reset on contents.
//   i_clk      : clock
//   i_wr_en    : write strobe, data lands at the rising edge
//   i_wr_idx   : write word index
//   i_wr_data  : write data
//   i_rd_idx   : read word index, sampled every rising edge
//   o_rd_data  : registered read data (one edge after i_rd_idx)
module dmem_array #(
    parameter int N  = 32,
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_idx,
    input  logic [N-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_idx,
    output logic [N-1:0]  o_rd_data
);

    logic [N-1:0] r_mem [2**AW];
    logic [N-1:0] r_rdData;

    // Single write port plus a registered read port. A read and a write to
    // the same word on the same edge return the old contents; the responder
    // never relies on that case.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        r_rdData <= r_mem[i_rd_idx];
    end

    assign o_rd_data = r_rdData;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Responder end of the memory-stage data port. Serves one load/store at a
// time against an internal word array and streams a full dump on halt.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_req_valid/rd/wr   : request strobe and kind
//   i_req_addr/wdata    : byte address, store data
//   o_req_ready         : request accepted when valid & ready
//   o_resp_valid        : one-cycle response pulse
//   o_resp_rdata/err    : load data / rejection flag, zero outside the pulse
//   i_halt              : level, dump after the outstanding op completes
//   o_dump_valid/addr/data : dump beat stream, word 0 .. 2**AW-1
//   o_dump_done         : sticky after the last beat until reset
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int N   = DATA_W,
    parameter int AW  = ADDR_W,
    parameter int LAT = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    input  logic          i_req_rd,
    input  logic          i_req_wr,
    input  logic [N-1:0]  i_req_addr,
    input  logic [N-1:0]  i_req_wdata,
    output logic          o_req_ready,
    output logic          o_resp_valid,
    output logic [N-1:0]  o_resp_rdata,
    output logic          o_resp_err,
    input  logic          i_halt,
    output logic          o_dump_valid,
    output logic [AW-1:0] o_dump_addr,
    output logic [N-1:0]  o_dump_data,
    output logic          o_dump_done
);

    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LAT - 1);
    localparam logic [AW:0]      LAST_BEAT = (AW+1)'(2**AW - 1);

    StateT            r_state;
    StateT            w_nextState;
    logic [LAT_W-1:0] r_latCnt;
    logic [AW:0]      r_dumpCnt;
    logic [AW-1:0]    r_loadIdx;
    logic             r_isLoad;
    logic             r_err;

    logic             w_accept;
    logic             w_reqErr;
    logic             w_wrEn;
    logic [AW-1:0]    w_wrIdx;
    logic [AW-1:0]    w_rdIdx;
    logic [N-1:0]     w_arrRdata;

    // The array's single read port serves both loads and the dump. Outside
    // RBUSY and DUMP it is pointed at word 0 so the first dump beat already
    // has its data when DUMP is entered; in DUMP it runs one word ahead.
    dmem_array #(
        .N  (N),
        .AW (AW)
    ) u_array (
        .i_clk     (i_clk),
        .i_wr_en   (w_wrEn),
        .i_wr_idx  (w_wrIdx),
        .i_wr_data (i_req_wdata),
        .i_rd_idx  (w_rdIdx),
        .o_rd_data (w_arrRdata)
    );

    assign w_wrIdx = word_index(i_req_addr);

    // State register plus the request latches and both counters. The latency
    // counter restarts on every accept and advances only while a load waits;
    // the dump counter only moves in DUMP, so it is 0 until the first halt
    // after reset and holds its final value once DONE is reached.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_latCnt  <= '0;
            r_dumpCnt <= '0;
            r_loadIdx <= '0;
            r_isLoad  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_loadIdx <= word_index(i_req_addr);
                r_isLoad  <= ~w_reqErr & i_req_rd;
                r_err     <= w_reqErr;
                r_latCnt  <= '0;
            end else if (r_state == RBUSY) begin
                r_latCnt <= r_latCnt + LAT_W'(1);
            end
            if (r_state == DUMP) begin
                r_dumpCnt <= r_dumpCnt + (AW+1)'(1);
            end
        end
    end

    // Next state and every output. Halt outranks a same-cycle request in
    // IDLE; stores write at the accept edge and answer immediately, loads
    // wait LAT cycles in RBUSY. Response and dump fields are forced to zero
    // whenever their valid is low.
    always_comb begin
        w_nextState  = r_state;
        w_reqErr     = addr_err(i_req_addr, i_req_rd, i_req_wr);
        w_accept     = 1'b0;
        w_wrEn       = 1'b0;
        w_rdIdx      = '0;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_resp_rdata = '0;
        o_resp_err   = 1'b0;
        o_dump_valid = 1'b0;
        o_dump_addr  = '0;
        o_dump_data  = '0;
        o_dump_done  = 1'b0;

        case (r_state)
            IDLE: begin
                o_req_ready = ~i_halt;
                w_accept    = i_req_valid & ~i_halt;
                if (i_halt) begin
                    w_nextState = DUMP;
                end else if (w_accept) begin
                    w_wrEn      = ~w_reqErr & i_req_wr;
                    w_nextState = (~w_reqErr & i_req_rd) ? RBUSY : RESP;
                end
            end
            RBUSY: begin
                w_rdIdx = r_loadIdx;
                if (r_latCnt == LAT_LAST) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                o_resp_valid = 1'b1;
                o_resp_err   = r_err;
                o_resp_rdata = r_isLoad ? w_arrRdata : '0;
                w_nextState  = i_halt ? DUMP : IDLE;
            end
            DUMP: begin
                o_dump_valid = 1'b1;
                o_dump_addr  = r_dumpCnt[AW-1:0];
                o_dump_data  = w_arrRdata;
                w_rdIdx      = r_dumpCnt[AW-1:0] + AW'(1);
                if (r_dumpCnt == LAST_BEAT) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                o_dump_done = 1'b1;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Three responders (LAT = 2, 1, 5) share one clock. Instance 0 carries the
// directed scenarios; instances 1 and 2 carry the random latency sweep.
// Expected values come from a word-array model and the request rules.
module tb_dmem_responder;

    logic        clk;
    logic        rst       [3];
    logic        halt      [3];
    logic        reqValid  [3];
    logic        reqRd     [3];
    logic        reqWr     [3];
    logic [31:0] reqAddr   [3];
    logic [31:0] reqWdata  [3];
    logic        reqReady  [3];
    logic        respValid [3];
    logic [31:0] respRdata [3];
    logic        respErr   [3];
    logic        dumpValid [3];
    logic [9:0]  dumpAddr  [3];
    logic [31:0] dumpData  [3];
    logic        dumpDone  [3];

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] refMem   [3][1024];
    bit          refKnown [3][1024];

    for (genvar g = 0; g < 3; g++) begin : gDut
        dmem_responder #(
            .N   (32),
            .AW  (10),
            .LAT (g == 1 ? 1 : (g == 2 ? 5 : 2))
        ) uDut (
            .i_clk        (clk),
            .i_rst        (rst[g]),
            .i_req_valid  (reqValid[g]),
            .i_req_rd     (reqRd[g]),
            .i_req_wr     (reqWr[g]),
            .i_req_addr   (reqAddr[g]),
            .i_req_wdata  (reqWdata[g]),
            .o_req_ready  (reqReady[g]),
            .o_resp_valid (respValid[g]),
            .o_resp_rdata (respRdata[g]),
            .o_resp_err   (respErr[g]),
            .i_halt       (halt[g]),
            .o_dump_valid (dumpValid[g]),
            .o_dump_addr  (dumpAddr[g]),
            .o_dump_data  (dumpData[g]),
            .o_dump_done  (dumpDone[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int latOf(input int k);
        if (k == 1) return 1;
        if (k == 2) return 5;
        return 2;
    endfunction

    // Request rules: exactly one of rd/wr, word aligned, inside 4 KiB.
    function automatic bit modelErr(input logic rd, input logic wr, input logic [31:0] addr);
        return (rd == wr) || (addr % 4 != 0) || (addr >= 32'd4096);
    endfunction

    function automatic int wordOf(input logic [31:0] addr);
        return int'((addr / 4) % 1024);
    endfunction

    // Drives one request from a negedge and observes it until the response
    // pulse. edges = rising edges after the accept edge before the pulse.
    task automatic applyStimulus(input int k, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic acceptReady, output int edges,
                                 output logic [31:0] rdata, output logic err,
                                 output logic readyLow, output logic pulseOk);
        @(negedge clk);
        reqValid[k] = 1'b1;
        reqRd[k]    = rd;
        reqWr[k]    = wr;
        reqAddr[k]  = addr;
        reqWdata[k] = wdata;
        #1 acceptReady = reqReady[k];
        @(negedge clk);
        reqValid[k] = 1'b0;
        reqRd[k]    = 1'b0;
        reqWr[k]    = 1'b0;
        edges       = 0;
        readyLow    = 1'b1;
        while (!respValid[k] && edges < 20) begin
            if (reqReady[k]) readyLow = 1'b0;
            @(negedge clk);
            edges++;
        end
        if (reqReady[k]) readyLow = 1'b0;
        rdata = respRdata[k];
        err   = respErr[k];
        @(negedge clk);
        pulseOk = !respValid[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; halt[k] = 1'b0; reqValid[k] = 1'b0; reqRd[k] = 1'b0;
            reqWr[k] = 1'b0; reqAddr[k] = '0; reqWdata[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            testsRun++;
            if (reqReady[k] !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_req_ready[%0d]: got %b expected 1", k, reqReady[k]); end
            testsRun++;
            if (respValid[k] !== 1'b0 || respErr[k] !== 1'b0 || respRdata[k] !== 32'h0) begin
                testsFailed++; $display("[TB] FAIL reset_resp[%0d]: got v=%b e=%b d=%h expected 0/0/0", k, respValid[k], respErr[k], respRdata[k]);
            end
            testsRun++;
            if (dumpValid[k] !== 1'b0 || dumpAddr[k] !== 10'h0 || dumpData[k] !== 32'h0 || dumpDone[k] !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL reset_dump[%0d]: got v=%b a=%h d=%h done=%b expected all 0", k, dumpValid[k], dumpAddr[k], dumpData[k], dumpDone[k]);
            end
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic acc, err, rl, po;
        logic [31:0] rdata, expData;
        int edges;
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, acc, edges, rdata, err, rl, po);
        refMem[0][wordOf(32'h10)] = 32'hDEADBEEF;
        refKnown[0][wordOf(32'h10)] = 1'b1;
        testsRun++; if (acc !== 1'b1) begin testsFailed++; $display("[TB] FAIL store_accept_ready: got %b expected 1", acc); end
        testsRun++; if (edges != 0) begin testsFailed++; $display("[TB] FAIL store_latency: got %0d expected 0 edges after accept", edges); end
        testsRun++; if (err !== 1'b0 || rdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL store_resp: got err=%b d=%h expected 0/0", err, rdata); end
        testsRun++; if (rl !== 1'b1 || po !== 1'b1) begin testsFailed++; $display("[TB] FAIL store_ready_pulse: got readyLow=%b pulseOk=%b expected 1/1", rl, po); end

        expData = refMem[0][wordOf(32'h10)];
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, acc, edges, rdata, err, rl, po);
        testsRun++; if (edges != latOf(0)) begin testsFailed++; $display("[TB] FAIL load_latency: got %0d expected %0d", edges, latOf(0)); end
        testsRun++; if (rdata !== expData || err !== 1'b0) begin testsFailed++; $display("[TB] FAIL load_data: got d=%h err=%b expected %h/0", rdata, err, expData); end
        testsRun++; if (acc !== 1'b1 || rl !== 1'b1 || po !== 1'b1) begin testsFailed++; $display("[TB] FAIL load_ready_pulse: got acc=%b readyLow=%b pulseOk=%b expected 1/1/1", acc, rl, po); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [6] = '{32'h13, 32'h0, 32'h1000, 32'h12, 32'h1010, 32'h10};
        logic [31:0] wdats [6] = '{32'h0, 32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D, 32'h0};
        logic        rds   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        wrs   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic acc, err, rl, po, expErr;
        logic [31:0] rdata, expData;
        int edges, expEdges;
        for (int i = 0; i < 6; i++) begin
            expErr   = modelErr(rds[i], wrs[i], addrs[i]);
            expEdges = (expErr || wrs[i]) ? 0 : latOf(0);
            expData  = (!expErr && rds[i]) ? refMem[0][wordOf(addrs[i])] : 32'h0;
            applyStimulus(0, rds[i], wrs[i], addrs[i], wdats[i], acc, edges, rdata, err, rl, po);
            testsRun++; if (err !== expErr) begin testsFailed++; $display("[TB] FAIL err_flag[%0d] @%h: got %b expected %b", i, addrs[i], err, expErr); end
            testsRun++; if (rdata !== expData) begin testsFailed++; $display("[TB] FAIL err_data[%0d] @%h: got %h expected %h", i, addrs[i], rdata, expData); end
            testsRun++; if (edges != expEdges || po !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_latency[%0d]: got %0d pulseOk=%b expected %0d/1", i, edges, po, expEdges); end
        end
    endtask

    task automatic test_async_reset();
        logic acc, err, rl, po;
        logic [31:0] rdata, expData;
        logic [31:0] loadAddrs [2] = '{32'h20, 32'h10};
        int edges, pulses;
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h55AA1234, acc, edges, rdata, err, rl, po);
        refMem[0][wordOf(32'h20)] = 32'h55AA1234;
        refKnown[0][wordOf(32'h20)] = 1'b1;
        testsRun++; if (err !== 1'b0 || edges != 0) begin testsFailed++; $display("[TB] FAIL rst_prestore: got err=%b edges=%0d expected 0/0", err, edges); end

        @(negedge clk);
        reqValid[0] = 1'b1; reqRd[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[0] = 32'h20;
        @(negedge clk);
        reqValid[0] = 1'b0; reqRd[0] = 1'b0;
        #2 rst[0] = 1'b1;
        #1;
        testsRun++;
        if (respValid[0] !== 1'b0 || reqReady[0] !== 1'b1 || respRdata[0] !== 32'h0 || respErr[0] !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rst_midload_outputs: got v=%b rdy=%b d=%h e=%b expected 0/1/0/0", respValid[0], reqReady[0], respRdata[0], respErr[0]);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        pulses = 0;
        repeat (latOf(0) + 4) begin
            @(negedge clk);
            if (respValid[0] !== 1'b0) pulses++;
        end
        testsRun++; if (pulses != 0) begin testsFailed++; $display("[TB] FAIL rst_dropped_resp: got %0d pulses expected 0", pulses); end

        for (int i = 0; i < 2; i++) begin
            expData = refMem[0][wordOf(loadAddrs[i])];
            applyStimulus(0, 1'b1, 1'b0, loadAddrs[i], 32'h0, acc, edges, rdata, err, rl, po);
            testsRun++; if (rdata !== expData || err !== 1'b0 || edges != latOf(0)) begin
                testsFailed++; $display("[TB] FAIL rst_retained[%0d]: got d=%h err=%b edges=%0d expected %h/0/%0d", i, rdata, err, edges, expData, latOf(0));
            end
        end
    endtask

    task automatic test_halt_priority();
        @(negedge clk);
        halt[0] = 1'b1;
        reqValid[0] = 1'b1; reqWr[0] = 1'b1; reqAddr[0] = 32'h10; reqWdata[0] = 32'hBAD0BAD0;
        #1;
        testsRun++; if (reqReady[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL halt_ready: got %b expected 0", reqReady[0]); end
        @(negedge clk);
        reqValid[0] = 1'b0; reqWr[0] = 1'b0;
        testsRun++; if (respValid[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL halt_no_resp: got %b expected 0", respValid[0]); end
        for (int i = 0; i < 1024; i++) begin
            testsRun++;
            if (dumpValid[0] !== 1'b1 || dumpAddr[0] !== 10'(i)) begin
                testsFailed++; $display("[TB] FAIL dump_beat[%0d]: got v=%b a=%0d expected 1/%0d", i, dumpValid[0], dumpAddr[0], i);
            end
            if (i == 4) begin
                testsRun++; if (dumpData[0] !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL dump_beat4_data: got %h expected deadbeef", dumpData[0]); end
            end else if (refKnown[0][i]) begin
                testsRun++; if (dumpData[0] !== refMem[0][i]) begin testsFailed++; $display("[TB] FAIL dump_data[%0d]: got %h expected %h", i, dumpData[0], refMem[0][i]); end
            end
            @(negedge clk);
        end
        testsRun++; if (dumpValid[0] !== 1'b0 || dumpDone[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL dump_end: got v=%b done=%b expected 0/1", dumpValid[0], dumpDone[0]); end
        halt[0] = 1'b0;
        repeat (5) @(negedge clk);
        testsRun++; if (dumpDone[0] !== 1'b1 || reqReady[0] !== 1'b0 || dumpValid[0] !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL done_sticky: got done=%b rdy=%b v=%b expected 1/0/0", dumpDone[0], reqReady[0], dumpValid[0]);
        end
    endtask

    task automatic test_halt_during_load();
        logic [31:0] expData;
        int edges;
        @(negedge clk); rst[0] = 1'b1;
        @(negedge clk); rst[0] = 1'b0;
        testsRun++; if (dumpDone[0] !== 1'b0 || reqReady[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL rerst_state: got done=%b rdy=%b expected 0/1", dumpDone[0], reqReady[0]); end
        expData = refMem[0][wordOf(32'h10)];
        reqValid[0] = 1'b1; reqRd[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[0] = 32'h10;
        @(negedge clk);
        reqValid[0] = 1'b0; reqRd[0] = 1'b0;
        halt[0] = 1'b1;
        edges = 0;
        while (!respValid[0] && edges < 20) begin @(negedge clk); edges++; end
        testsRun++; if (edges != latOf(0)) begin testsFailed++; $display("[TB] FAIL haltload_latency: got %0d expected %0d", edges, latOf(0)); end
        testsRun++; if (respRdata[0] !== expData || respErr[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL haltload_data: got %h err=%b expected %h/0", respRdata[0], respErr[0], expData); end
        @(negedge clk);
        for (int i = 0; i < 1024; i++) begin
            if (i == 500) halt[0] = 1'b0;
            testsRun++;
            if (dumpValid[0] !== 1'b1 || dumpAddr[0] !== 10'(i)) begin
                testsFailed++; $display("[TB] FAIL haltload_beat[%0d]: got v=%b a=%0d expected 1/%0d", i, dumpValid[0], dumpAddr[0], i);
            end
            if (refKnown[0][i]) begin
                testsRun++; if (dumpData[0] !== refMem[0][i]) begin testsFailed++; $display("[TB] FAIL haltload_data[%0d]: got %h expected %h", i, dumpData[0], refMem[0][i]); end
            end
            @(negedge clk);
        end
        testsRun++; if (dumpValid[0] !== 1'b0 || dumpDone[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL haltload_end: got v=%b done=%b expected 0/1", dumpValid[0], dumpDone[0]); end
    endtask

    task automatic test_latency_sweep();
        logic acc, err, rl, po;
        logic [31:0] rdata, data, expData;
        int edges, idx, pick;
        int stored [$];
        for (int k = 1; k < 3; k++) begin
            stored.delete();
            for (int n = 0; n < 100; n++) begin
                idx  = int'($urandom_range(0, 63));
                data = $urandom;
                applyStimulus(k, 1'b0, 1'b1, 32'(idx * 4), data, acc, edges, rdata, err, rl, po);
                refMem[k][idx] = data;
                refKnown[k][idx] = 1'b1;
                stored.push_back(idx);
                testsRun++; if (err !== 1'b0 || edges != 0) begin testsFailed++; $display("[TB] FAIL sweep_store[%0d.%0d]: got err=%b edges=%0d expected 0/0", k, n, err, edges); end

                pick    = stored[$urandom_range(0, stored.size() - 1)];
                expData = refMem[k][pick];
                applyStimulus(k, 1'b1, 1'b0, 32'(pick * 4), 32'h0, acc, edges, rdata, err, rl, po);
                testsRun++; if (edges != latOf(k)) begin testsFailed++; $display("[TB] FAIL sweep_latency[%0d.%0d]: got %0d expected %0d", k, n, edges, latOf(k)); end
                testsRun++; if (rdata !== expData || err !== 1'b0) begin testsFailed++; $display("[TB] FAIL sweep_data[%0d.%0d] word %0d: got %h err=%b expected %h/0", k, n, pick, rdata, err, expData); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 1024; w++) begin
                refKnown[k][w] = 1'b0;
                refMem[k][w]   = 32'h0;
            end
        end
        test_reset();
        test_store_load();
        test_errors();
        test_async_reset();
        test_halt_priority();
        test_halt_during_load();
        test_latency_sweep();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
